// File: rtl/accum_job_scheduler.sv
// Two-requester round-robin scheduler for a shared adder/register accumulator.
// Each accepted job computes opA * cnt (mod 2^W) by repeated addition and
// reports completion with a one-cycle done pulse tagged with the requester id.

// Ripple-free behavioural W-bit adder with carry in/out.
module Adder #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Cin,
   output logic [W-1:0] S,
   output logic         Cout
);

   localparam int unsigned SW = W + 1;

   // Full-width sum; the top bit is the carry out.
   assign {Cout, S} = SW'(A) + SW'(B) + SW'(Cin);

endmodule

// W-bit register with load enable and synchronous clear.
module Register #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear takes precedence over load whenever the register is enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= clear ? '0 : d;
      end
   end

endmodule

module accum_job_scheduler #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [W-1:0]  opA0,
   input  logic [CW-1:0] cnt0,
   input  logic [W-1:0]  opA1,
   input  logic [CW-1:0] cnt1,
   output logic [1:0]    grant,
   output logic          busy,
   output logic          done,
   output logic          doneId,
   output logic [W-1:0]  result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic          ptr;
   logic [W-1:0]  opa_q;
   logic [CW-1:0] rem_q;
   logic          id_q;

   logic          winner;
   logic          accept;
   logic [W-1:0]  sel_opa;
   logic [CW-1:0] sel_cnt;

   logic [W-1:0]  acc;
   logic [W-1:0]  sum;
   logic          add_cout;
   logic          acc_en;
   logic          acc_clear;
   logic          unused_cout;

   // Round-robin pick: the pointer's requester wins if asking, else the other.
   always_comb begin
      winner = ptr;
      if (!req[ptr]) begin
         winner = ~ptr;
      end
   end

   // Grant only in IDLE and never while reset is being applied.
   always_comb begin
      grant = 2'b00;
      if (!reset && (state == IDLE) && (req != 2'b00)) begin
         grant[winner] = 1'b1;
      end
   end

   assign accept  = |grant;
   assign sel_opa = winner ? opA1 : opA0;
   assign sel_cnt = winner ? cnt1 : cnt0;

   // Accumulator control: zero on accept (and on reset), add every ADD cycle.
   assign acc_en    = accept | (state == ADD) | reset;
   assign acc_clear = accept | reset;

   Adder #(.W(W)) u_adder (
      .A    (acc),
      .B    (opa_q),
      .Cin  (1'b0),
      .S    (sum),
      .Cout (add_cout)
   );

   Register #(.W(W)) u_acc (
      .clk   (clock),
      .rst   (1'b0),
      .en    (acc_en),
      .clear (acc_clear),
      .d     (sum),
      .q     (acc)
   );

   // Carry is dropped: the accumulator wraps modulo 2^W.
   assign unused_cout = add_cout;

   assign result = acc;

   // Job sequencer: latch winner's job, count down the adds, pulse done once.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         doneId <= 1'b0;
         opa_q  <= '0;
         rem_q  <= '0;
         id_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  opa_q <= sel_opa;
                  rem_q <= sel_cnt;
                  id_q  <= winner;
                  ptr   <= ~winner;
                  busy  <= 1'b1;
                  if (sel_cnt != '0) begin
                     state <= ADD;
                  end else begin
                     state  <= DONE;
                     done   <= 1'b1;
                     doneId <= winner;
                  end
               end
            end
            ADD: begin
               rem_q <= rem_q - CW'(1);
               if (rem_q == CW'(1)) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  doneId <= id_q;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
